// File: rtl/bcd_alu_pkg.sv
// Shared definitions for the BCD arithmetic sequencer.
// Covers op codes, sequencer states and the digit-range check.
package bcd_alu_pkg;

  typedef enum logic [1:0] {
    OP_ADD = 2'b00,
    OP_SUB = 2'b01,
    OP_MUL = 2'b10,
    OP_RSV = 2'b11
  } op_e;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LOAD   = 3'd1,
    ST_ADD    = 3'd2,
    ST_SUB    = 3'd3,
    ST_MSHIFT = 3'd4,
    ST_MADD   = 3'd5,
    ST_FIN    = 3'd6
  } state_e;

  // A BCD nibble is valid only in the range 0..9
  function automatic logic digit_ok(input logic [3:0] d);
    return d <= 4'd9;
  endfunction

endpackage

// File: rtl/bcd_alu_seq_digit.sv
// Single-digit BCD adder/subtractor with carry/borrow in and out.
// When sub is high, cin/cout act as borrow and the result is corrected by +10.
module bcd_digit_addsub (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       cin,
  input  logic       sub,
  output logic [3:0] digit,
  output logic       cout
);

  logic [4:0] raw;

  always_comb begin
    raw   = 5'd0;
    digit = 4'd0;
    cout  = 1'b0;
    if (sub) begin
      raw = {1'b0, a} - {1'b0, b} - 5'(cin);
      if (raw[4]) begin
        digit = 4'(raw + 5'd10);
        cout  = 1'b1;
      end else begin
        digit = raw[3:0];
      end
    end else begin
      raw = {1'b0, a} + {1'b0, b} + 5'(cin);
      if (raw > 5'd9) begin
        digit = 4'(raw - 5'd10);
        cout  = 1'b1;
      end else begin
        digit = raw[3:0];
      end
    end
  end

endmodule

// File: rtl/bcd_alu_seq.sv
// Multi-cycle BCD ALU: digit-serial add/sub, shift-and-repeated-add multiply.
// Start/busy/done handshake; result, neg and err hold until the next accepted start.
module bcd_alu_seq
  import bcd_alu_pkg::*;
#(
  parameter int unsigned DIGITS = 4
) (
  input  logic                  clk,
  input  logic                  clr_n,
  input  logic                  start,
  input  logic [1:0]            op,
  input  logic [4*DIGITS-1:0]   a_bcd,
  input  logic [4*DIGITS-1:0]   b_bcd,
  output logic                  busy,
  output logic                  done,
  output logic [8*DIGITS-1:0]   result_bcd,
  output logic                  neg,
  output logic                  err
);

  localparam int unsigned AW = 4 * DIGITS;
  localparam int unsigned RW = 8 * DIGITS;
  localparam int unsigned ND = 2 * DIGITS;
  localparam int unsigned IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [IW-1:0] LAST = IW'(DIGITS - 1);

  state_e          state_q, state_d;
  op_e             op_q, op_d;
  logic [AW-1:0]   a_q, a_d, b_q, b_d;
  logic [RW-1:0]   acc_q, acc_d;
  logic            carry_q, carry_d;
  logic [IW-1:0]   idx_q, idx_d;
  logic [3:0]      rep_q, rep_d;
  logic            busy_d, done_d, neg_d, err_d;
  logic [RW-1:0]   result_d;

  logic [3:0]      ser_a, ser_b, ser_dig, b_dig;
  logic            ser_cout;
  logic            operands_ok;

  assign ser_a = a_q[4*idx_q +: 4];
  assign ser_b = b_q[4*idx_q +: 4];
  assign b_dig = ser_b;

  bcd_digit_addsub u_serial (
    .a     (ser_a),
    .b     (ser_b),
    .cin   (carry_q),
    .sub   (state_q == ST_SUB),
    .digit (ser_dig),
    .cout  (ser_cout)
  );

  // Full-width accumulator adder for acc + A in one cycle
  logic [ND:0]   mc;
  logic [RW-1:0] madd_sum;
  logic          madd_ovf;

  assign mc[0]    = 1'b0;
  assign madd_ovf = mc[ND];

  for (genvar i = 0; i < ND; i++) begin : g_madd
    logic [3:0] addend;
    if (i < DIGITS) begin : g_lo
      assign addend = a_q[4*i +: 4];
    end else begin : g_hi
      assign addend = 4'd0;
    end
    bcd_digit_addsub u_dig (
      .a     (acc_q[4*i +: 4]),
      .b     (addend),
      .cin   (mc[i]),
      .sub   (1'b0),
      .digit (madd_sum[4*i +: 4]),
      .cout  (mc[i+1])
    );
  end

  always_comb begin
    operands_ok = 1'b1;
    for (int unsigned i = 0; i < DIGITS; i++) begin
      if (!digit_ok(a_q[4*i +: 4]) || !digit_ok(b_q[4*i +: 4])) operands_ok = 1'b0;
    end
  end

  // Next-state and datapath update
  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    a_d      = a_q;
    b_d      = b_q;
    acc_d    = acc_q;
    carry_d  = carry_q;
    idx_d    = idx_q;
    rep_d    = rep_q;
    neg_d    = neg;
    err_d    = err;
    result_d = result_bcd;
    done_d   = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          a_d      = a_bcd;
          b_d      = b_bcd;
          op_d     = op_e'(op);
          acc_d    = '0;
          result_d = '0;
          neg_d    = 1'b0;
          err_d    = 1'b0;
          state_d  = ST_LOAD;
        end
      end
      ST_LOAD: begin
        acc_d   = '0;
        carry_d = 1'b0;
        idx_d   = '0;
        // Error path spends a second cycle here so done lands after E2
        if (err) begin
          state_d = ST_FIN;
        end else if (!operands_ok || op_q == OP_RSV) begin
          err_d = 1'b1;
        end else begin
          case (op_q)
            OP_ADD: state_d = ST_ADD;
            OP_SUB: begin
              if (a_q < b_q) begin
                a_d   = b_q;
                b_d   = a_q;
                neg_d = 1'b1;
              end
              state_d = ST_SUB;
            end
            default: begin
              idx_d   = LAST;
              state_d = ST_MSHIFT;
            end
          endcase
        end
      end
      ST_ADD, ST_SUB: begin
        acc_d[4*idx_q +: 4] = ser_dig;
        carry_d             = ser_cout;
        if (idx_q == LAST) begin
          acc_d[AW +: 4] = {3'b000, ser_cout};
          state_d        = ST_FIN;
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end
      ST_MSHIFT: begin
        acc_d = {acc_q[RW-5:0], 4'd0};
        rep_d = b_dig;
        if (b_dig != 4'd0) begin
          state_d = ST_MADD;
        end else if (idx_q == '0) begin
          state_d = ST_FIN;
        end else begin
          idx_d = idx_q - 1'b1;
        end
      end
      ST_MADD: begin
        acc_d = madd_sum;
        rep_d = rep_q - 4'd1;
        if (madd_ovf) err_d = 1'b1;
        if (rep_q == 4'd1) begin
          if (idx_q == '0) begin
            state_d = ST_FIN;
          end else begin
            idx_d   = idx_q - 1'b1;
            state_d = ST_MSHIFT;
          end
        end
      end
      ST_FIN:  state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase

    if (state_d == ST_FIN && state_q != ST_FIN) begin
      result_d = acc_d;
      done_d   = 1'b1;
    end
    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      state_q    <= ST_IDLE;
      op_q       <= OP_ADD;
      a_q        <= '0;
      b_q        <= '0;
      acc_q      <= '0;
      carry_q    <= 1'b0;
      idx_q      <= '0;
      rep_q      <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      neg        <= 1'b0;
      err        <= 1'b0;
      result_bcd <= '0;
    end else begin
      state_q    <= state_d;
      op_q       <= op_d;
      a_q        <= a_d;
      b_q        <= b_d;
      acc_q      <= acc_d;
      carry_q    <= carry_d;
      idx_q      <= idx_d;
      rep_q      <= rep_d;
      busy       <= busy_d;
      done       <= done_d;
      neg        <= neg_d;
      err        <= err_d;
      result_bcd <= result_d;
    end
  end

endmodule

// File: tb/tb_bcd_alu_seq.sv
// Self-checking bench for bcd_alu_seq: directed cases plus random operations
// compared against an integer-arithmetic reference model.
module tb_bcd_alu_seq;

  localparam int unsigned DIGITS = 4;

  logic        clk = 1'b0;
  logic        clr_n;
  logic        start;
  logic [1:0]  op;
  logic [15:0] a_bcd, b_bcd;
  logic        busy, done, neg, err;
  logic [31:0] result_bcd;

  int compared   = 0;
  int mismatched = 0;

  int  hold_t, hold_n;
  int  hold_d [3];
  bit  saw_done;

  always #5 clk = ~clk;

  bcd_alu_seq #(.DIGITS(DIGITS)) dut (
    .clk        (clk),
    .clr_n      (clr_n),
    .start      (start),
    .op         (op),
    .a_bcd      (a_bcd),
    .b_bcd      (b_bcd),
    .busy       (busy),
    .done       (done),
    .result_bcd (result_bcd),
    .neg        (neg),
    .err        (err)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic longint unsigned bcd_val(input logic [15:0] v);
    longint unsigned r = 0;
    for (int i = 3; i >= 0; i--) r = r * 10 + 64'(v[4*i +: 4]);
    return r;
  endfunction

  function automatic logic [31:0] to_bcd(input longint unsigned x);
    logic [31:0] r = '0;
    longint unsigned t = x;
    for (int i = 0; i < 8; i++) begin
      r[4*i +: 4] = 4'(t % 10);
      t = t / 10;
    end
    return r;
  endfunction

  function automatic bit has_bad(input logic [15:0] v);
    for (int i = 0; i < 4; i++) if (v[4*i +: 4] > 4'd9) return 1'b1;
    return 1'b0;
  endfunction

  // One operation: expected values from plain arithmetic; latency counted in edges after E0
  task automatic run_op(input string tag, input logic [15:0] a, input logic [15:0] b,
                        input logic [1:0] o, input bit noise);
    longint unsigned av, bv, rv;
    logic [31:0] exp_res;
    bit exp_neg = 0, exp_err = 0, seen = 0, busy_ok = 1;
    int exp_lat, n = 0;
    av = bcd_val(a);
    bv = bcd_val(b);
    rv = 0;
    if (has_bad(a) || has_bad(b) || o == 2'b11) begin
      exp_err = 1;
      exp_lat = 2;
    end else begin
      case (o)
        2'b00: begin rv = av + bv; exp_lat = DIGITS + 1; end
        2'b01: begin
          if (av < bv) begin rv = bv - av; exp_neg = 1; end
          else rv = av - bv;
          exp_lat = DIGITS + 1;
        end
        default: begin
          rv = av * bv;
          exp_lat = DIGITS + 1;
          for (int i = 0; i < 4; i++) exp_lat += int'(b[4*i +: 4]);
        end
      endcase
    end
    exp_res = to_bcd(rv);

    a_bcd = a; b_bcd = b; op = o; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    while (!seen && n < 60) begin
      if (noise) begin
        start = n[0];
        a_bcd = 16'($urandom);
        b_bcd = 16'($urandom);
        op    = 2'($urandom);
      end
      @(posedge clk); #1;
      n++;
      if (busy !== 1'b1) busy_ok = 0;
      if (done === 1'b1) seen = 1;
    end
    start = 1'b0;
    check({tag, "/latency"}, 64'(n), 64'(exp_lat));
    check({tag, "/result"}, result_bcd, exp_res);
    check({tag, "/neg"}, neg, exp_neg);
    check({tag, "/err"}, err, exp_err);
    check({tag, "/busy_during"}, busy_ok, 1);
    @(posedge clk); #1;
    check({tag, "/done_one_cycle"}, done, 0);
    check({tag, "/busy_after"}, busy, 0);
    @(posedge clk); #1;
    check({tag, "/result_hold"}, result_bcd, exp_res);
  endtask

  function automatic logic [15:0] rand_bcd(input bit allow_bad);
    logic [15:0] v;
    for (int i = 0; i < 4; i++) v[4*i +: 4] = 4'($urandom_range(0, 9));
    if (allow_bad && $urandom_range(0, 7) == 0)
      v[4*$urandom_range(0, 3) +: 4] = 4'($urandom_range(10, 15));
    return v;
  endfunction

  initial begin
    clr_n = 1'b0; start = 1'b0; op = 2'b00; a_bcd = '0; b_bcd = '0;
    #12;
    check("reset/busy", busy, 0);
    check("reset/done", done, 0);
    check("reset/result", result_bcd, 0);
    check("reset/neg", neg, 0);
    check("reset/err", err, 0);
    @(negedge clk); clr_n = 1'b1;
    @(posedge clk); #1;

    run_op("add_max", 16'h9999, 16'h9999, 2'b00, 0);
    run_op("sub_neg", 16'h0123, 16'h0456, 2'b01, 0);
    run_op("sub_eq", 16'h0777, 16'h0777, 2'b01, 0);
    run_op("mul_basic", 16'h1234, 16'h5678, 2'b10, 0);
    run_op("mul_b0", 16'h4321, 16'h0000, 2'b10, 0);
    run_op("mul_max", 16'h9999, 16'h9999, 2'b10, 0);
    run_op("err_digit", 16'h12A4, 16'h0001, 2'b00, 0);
    run_op("err_op", 16'h1234, 16'h0042, 2'b11, 0);
    run_op("err_clear", 16'h0005, 16'h0007, 2'b00, 0);
    run_op("busy_noise", 16'h0246, 16'h0135, 2'b10, 1);

    // Continuous start: restarts only from IDLE, one extra idle cycle between ops
    a_bcd = 16'h1111; b_bcd = 16'h2222; op = 2'b00; start = 1'b1;
    hold_t = 0; hold_n = 0;
    foreach (hold_d[i]) hold_d[i] = 0;
    while (hold_n < 3 && hold_t < 100) begin
      @(posedge clk); #1;
      hold_t++;
      if (done === 1'b1) begin hold_d[hold_n] = hold_t; hold_n++; end
    end
    start = 1'b0;
    check("hold/count", 64'(hold_n), 3);
    check("hold/gap1", 64'(hold_d[1] - hold_d[0]), 7);
    check("hold/gap2", 64'(hold_d[2] - hold_d[1]), 7);
    check("hold/result", result_bcd, 32'h0000_3333);
    repeat (3) @(posedge clk);
    #1;

    // Reset in the middle of MADD
    a_bcd = 16'h9999; b_bcd = 16'h9999; op = 2'b10; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (6) begin @(posedge clk); #1; end
    check("midreset/busy_before", busy, 1);
    clr_n = 1'b0;
    #1;
    check("midreset/outputs", {busy, done, neg, err, result_bcd}, 36'd0);
    @(negedge clk); clr_n = 1'b1;
    saw_done = 0;
    repeat (50) begin
      @(posedge clk); #1;
      if (done === 1'b1) saw_done = 1;
    end
    check("midreset/no_done", saw_done, 0);
    run_op("after_reset", 16'h0050, 16'h0049, 2'b01, 0);

    for (int t = 0; t < 30; t++) begin
      logic [1:0] ro;
      ro = ($urandom_range(0, 9) == 0) ? 2'b11 : 2'($urandom_range(0, 2));
      run_op($sformatf("rand%0d", t), rand_bcd(1), rand_bcd(1), ro, t[0]);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
